// File: rtl/spirit_line_scanner.sv
// rtl/spirit_line_scanner.sv - per-scanline sprite walker with active list and 1-cycle pixel hit query
module spirit_line_scanner #(
    parameter int MAX_ACTIVE = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_line_start,
    input  logic [9:0]  i_line_y,
    output logic [4:0]  o_spirit_idx,
    input  logic [63:0] i_spirit_position_struct,
    input  logic [9:0]  i_pixel_x,
    output logic        o_hit,
    output logic [4:0]  o_hit_idx,
    output logic [4:0]  o_tex_id,
    output logic [7:0]  o_tex_u,
    output logic [7:0]  o_tex_v,
    output logic        o_scan_busy,
    output logic        o_scan_done,
    output logic [3:0]  o_active_count,
    output logic        o_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index k is issued when rd_cnt == k and its struct is judged RD_LATENCY
    // cycles later, so the last evaluation happens at 31 + RD_LATENCY.
    localparam logic [5:0] SCAN_LAT   = 6'(RD_LATENCY);
    localparam logic [5:0] SCAN_END   = 6'(31 + RD_LATENCY);
    localparam logic [3:0] MAX_COUNT  = 4'(MAX_ACTIVE);

    state_t      state;
    logic [5:0]  rd_cnt;
    logic [9:0]  line_y;

    logic [4:0]  ent_idx [MAX_ACTIVE];
    logic [9:0]  ent_x   [MAX_ACTIVE];
    logic [7:0]  ent_w   [MAX_ACTIVE];
    logic [4:0]  ent_tex [MAX_ACTIVE];
    logic [7:0]  ent_v   [MAX_ACTIVE];

    // Sprite struct fields
    logic [9:0]  sp_x;
    logic [9:0]  sp_y;
    logic [7:0]  sp_w;
    logic [7:0]  sp_h;
    logic [4:0]  sp_tex;
    logic        sp_en;
    logic        unused_struct_bits;

    assign sp_x   = i_spirit_position_struct[9:0];
    assign sp_y   = i_spirit_position_struct[25:16];
    assign sp_w   = i_spirit_position_struct[39:32];
    assign sp_h   = i_spirit_position_struct[47:40];
    assign sp_tex = i_spirit_position_struct[52:48];
    assign sp_en  = i_spirit_position_struct[63];
    assign unused_struct_bits = ^{i_spirit_position_struct[15:10],
                                  i_spirit_position_struct[31:26],
                                  i_spirit_position_struct[62:53]};

    // 11-bit compare so sprites reaching past line 1023 do not wrap
    logic [10:0] ly_ext;
    logic [10:0] y_lo;
    logic [10:0] y_hi;
    logic        line_hit;
    logic [7:0]  row_v;
    logic        eval_now;
    logic [4:0]  eval_idx;

    assign ly_ext   = {1'b0, line_y};
    assign y_lo     = {1'b0, sp_y};
    assign y_hi     = y_lo + {3'b000, sp_h};
    assign line_hit = sp_en && (ly_ext >= y_lo) && (ly_ext <= y_hi);
    assign row_v    = 8'(line_y - sp_y);
    assign eval_now = (state == SCAN) && (rd_cnt >= SCAN_LAT);
    assign eval_idx = 5'(rd_cnt - SCAN_LAT);

    // Scan FSM: issue indices, judge returned structs, build the active list
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rd_cnt         <= '0;
            line_y         <= '0;
            o_spirit_idx   <= '0;
            o_scan_busy    <= 1'b0;
            o_scan_done    <= 1'b0;
            o_active_count <= '0;
            o_overflow     <= 1'b0;
            for (int i = 0; i < MAX_ACTIVE; i++) begin
                ent_idx[i] <= '0;
                ent_x[i]   <= '0;
                ent_w[i]   <= '0;
                ent_tex[i] <= '0;
                ent_v[i]   <= '0;
            end
        end else if (i_line_start) begin
            state          <= SCAN;
            rd_cnt         <= '0;
            line_y         <= i_line_y;
            o_spirit_idx   <= '0;
            o_scan_busy    <= 1'b1;
            o_scan_done    <= 1'b0;
            o_active_count <= '0;
            o_overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_spirit_idx <= '0;
                end
                SCAN: begin
                    if (eval_now && line_hit) begin
                        if (o_active_count < MAX_COUNT) begin
                            for (int i = 0; i < MAX_ACTIVE; i++) begin
                                if (4'(i) == o_active_count) begin
                                    ent_idx[i] <= eval_idx;
                                    ent_x[i]   <= sp_x;
                                    ent_w[i]   <= sp_w;
                                    ent_tex[i] <= sp_tex;
                                    ent_v[i]   <= row_v;
                                end
                            end
                            o_active_count <= o_active_count + 4'd1;
                        end else begin
                            o_overflow <= 1'b1;
                        end
                    end
                    if (rd_cnt == SCAN_END) begin
                        state        <= DONE;
                        o_spirit_idx <= '0;
                        o_scan_busy  <= 1'b0;
                        o_scan_done  <= 1'b1;
                    end else begin
                        rd_cnt       <= rd_cnt + 6'd1;
                        o_spirit_idx <= (rd_cnt < 6'd31) ? 5'(rd_cnt + 6'd1) : 5'd0;
                    end
                end
                DONE: begin
                    o_spirit_idx <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pixel match: lowest list position covering the pixel wins
    logic [10:0] px_ext;
    logic        q_hit;
    logic [4:0]  q_idx;
    logic [4:0]  q_tex;
    logic [7:0]  q_u;
    logic [7:0]  q_v;

    assign px_ext = {1'b0, i_pixel_x};

    // Walk from the top so the lowest matching position is the last writer
    always_comb begin
        q_hit = 1'b0;
        q_idx = '0;
        q_tex = '0;
        q_u   = '0;
        q_v   = '0;
        for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
            if ((4'(i) < o_active_count) &&
                (px_ext >= {1'b0, ent_x[i]}) &&
                (px_ext <= ({1'b0, ent_x[i]} + {3'b000, ent_w[i]}))) begin
                q_hit = 1'b1;
                q_idx = ent_idx[i];
                q_tex = ent_tex[i];
                q_u   = 8'(i_pixel_x - ent_x[i]);
                q_v   = ent_v[i];
            end
        end
    end

    // Registered query result, forced to zero unless the list is complete
    always_ff @(posedge clk) begin
        if (rst) begin
            o_hit     <= 1'b0;
            o_hit_idx <= '0;
            o_tex_id  <= '0;
            o_tex_u   <= '0;
            o_tex_v   <= '0;
        end else if ((state == DONE) && q_hit) begin
            o_hit     <= 1'b1;
            o_hit_idx <= q_idx;
            o_tex_id  <= q_tex;
            o_tex_u   <= q_u;
            o_tex_v   <= q_v;
        end else begin
            o_hit     <= 1'b0;
            o_hit_idx <= '0;
            o_tex_id  <= '0;
            o_tex_u   <= '0;
            o_tex_v   <= '0;
        end
    end

endmodule

// File: tb/tb_spirit_line_scanner.sv
// tb/tb_spirit_line_scanner.sv - scoreboard bench for spirit_line_scanner
module tb_spirit_line_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_line_start;
    logic [9:0]  i_line_y;
    logic [4:0]  o_spirit_idx;
    logic [63:0] i_spirit_position_struct;
    logic [9:0]  i_pixel_x;
    logic        o_hit;
    logic [4:0]  o_hit_idx;
    logic [4:0]  o_tex_id;
    logic [7:0]  o_tex_u;
    logic [7:0]  o_tex_v;
    logic        o_scan_busy;
    logic        o_scan_done;
    logic [3:0]  o_active_count;
    logic        o_overflow;

    spirit_line_scanner dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_line_start             (i_line_start),
        .i_line_y                 (i_line_y),
        .o_spirit_idx             (o_spirit_idx),
        .i_spirit_position_struct (i_spirit_position_struct),
        .i_pixel_x                (i_pixel_x),
        .o_hit                    (o_hit),
        .o_hit_idx                (o_hit_idx),
        .o_tex_id                 (o_tex_id),
        .o_tex_u                  (o_tex_u),
        .o_tex_v                  (o_tex_v),
        .o_scan_busy              (o_scan_busy),
        .o_scan_done              (o_scan_done),
        .o_active_count           (o_active_count),
        .o_overflow               (o_overflow)
    );

    always #5 clk = ~clk;

    // Sprite memory with one cycle of read latency
    logic [63:0] mem [32];
    always @(posedge clk) i_spirit_position_struct <= mem[o_spirit_idx];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       hit;
        logic [4:0] idx;
        logic [4:0] tex;
        logic [7:0] u;
        logic [7:0] v;
    } exp_t;

    exp_t exp_q[$];

    // Reference list for the current line
    int  m_idx[$];
    int  m_x[$];
    int  m_w[$];
    int  m_tex[$];
    int  m_v[$];
    bit  m_ovf;
    bit  m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int x, input int y, input int w, input int h,
                                        input int tex, input bit en);
        logic [63:0] s;
        s        = '0;
        s[9:0]   = 10'(x);
        s[25:16] = 10'(y);
        s[39:32] = 8'(w);
        s[47:40] = 8'(h);
        s[52:48] = 5'(tex);
        s[63]    = en;
        return s;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    // Which sprites cover line ly, in index order, capped at eight
    task automatic build_model(input int ly);
        m_idx.delete(); m_x.delete(); m_w.delete(); m_tex.delete(); m_v.delete();
        m_ovf = 0;
        for (int i = 0; i < 32; i++) begin
            int x, y, w, h;
            x = int'(mem[i][9:0]);   y = int'(mem[i][25:16]);
            w = int'(mem[i][39:32]); h = int'(mem[i][47:40]);
            if (mem[i][63] && ly >= y && ly <= y + h) begin
                if (m_idx.size() < 8) begin
                    m_idx.push_back(i); m_x.push_back(x); m_w.push_back(w);
                    m_tex.push_back(int'(mem[i][52:48])); m_v.push_back((ly - y) % 256);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic push_exp(input bit hit, input int idx, input int tex, input int u, input int v);
        exp_t e;
        e.hit = hit; e.idx = 5'(idx); e.tex = 5'(tex); e.u = 8'(u); e.v = 8'(v);
        exp_q.push_back(e);
    endtask

    // Drive one query at the current negedge with a directed expectation
    task automatic query_direct(input int px, input bit hit, input int idx, input int tex,
                                input int u, input int v);
        i_pixel_x = 10'(px);
        push_exp(hit, idx, tex, u, v);
        @(negedge clk);
    endtask

    // Drive one query with the expectation taken from the reference list
    task automatic query_model(input int px);
        bit found;
        found = 0;
        i_pixel_x = 10'(px);
        if (m_done) begin
            for (int i = 0; i < m_idx.size() && !found; i++) begin
                if (px >= m_x[i] && px <= m_x[i] + m_w[i]) begin
                    push_exp(1, m_idx[i], m_tex[i], (px - m_x[i]) % 256, m_v[i]);
                    found = 1;
                end
            end
        end
        if (!found) push_exp(0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    // Called at a negedge; returns at the negedge of scan cycle 0
    task automatic start_scan(input int ly);
        i_line_start = 1'b1;
        i_line_y     = 10'(ly);
        m_done       = 0;
        @(negedge clk);
        i_line_start = 1'b0;
        check("idx_restart", 32'(o_spirit_idx), 0);
        check("busy_at_start", 32'(o_scan_busy), 1);
        check("done_clear", 32'(o_scan_done), 0);
        check("ovf_clear", 32'(o_overflow), 0);
        check("count_clear", 32'(o_active_count), 0);
    endtask

    task automatic wait_done(input int ly);
        int n;
        n = 0;
        while (!o_scan_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scan_latency", 32'(n), 33);
        check("busy_after", 32'(o_scan_busy), 0);
        build_model(ly);
        m_done = (n < 100);
        check("active_count", 32'(o_active_count), 32'(m_idx.size()));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic scan(input int ly);
        start_scan(ly);
        wait_done(ly);
    endtask

    // Monitor: outputs one edge after a query reflect that query
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if ({o_hit, o_hit_idx, o_tex_id, o_tex_u, o_tex_v} !== {e.hit, e.idx, e.tex, e.u, e.v}) begin
                n_fail++;
                $display("FAIL query: got hit=%0d idx=%0d tex=%0d u=%0d v=%0d expected hit=%0d idx=%0d tex=%0d u=%0d v=%0d",
                         o_hit, o_hit_idx, o_tex_id, o_tex_u, o_tex_v, e.hit, e.idx, e.tex, e.u, e.v);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_line_start = 1'b0; i_line_y = '0; i_pixel_x = '0;
        m_done = 0; m_ovf = 0;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_hit", 32'(o_hit), 0);
        check("rst_done", 32'(o_scan_done), 0);
        check("rst_busy", 32'(o_scan_busy), 0);
        check("rst_idx", 32'(o_spirit_idx), 0);
        check("rst_count", 32'(o_active_count), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        query_direct(100, 0, 0, 0, 0, 0);
        drain();

        // Single sprite
        mem[3] = mk(100, 50, 15, 15, 7, 1);
        scan(60);
        check("single_count", 32'(o_active_count), 1);
        query_direct(105, 1, 3, 7, 5, 10);
        query_direct(116, 0, 0, 0, 0, 0);
        query_direct(115, 1, 3, 7, 15, 10);
        query_direct(99, 0, 0, 0, 0, 0);
        drain();

        // Priority between overlapping sprites
        clear_mem();
        mem[2] = mk(200, 5, 10, 10, 1, 1);
        mem[9] = mk(195, 8, 20, 4, 2, 1);
        scan(10);
        query_direct(200, 1, 2, 1, 0, 5);
        drain();
        mem[2][63] = 1'b0;
        scan(10);
        query_direct(200, 1, 9, 2, 5, 2);
        drain();

        // Overflow with ten sprites on one line
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i * 3] = mk(i * 50, 0, 20, 10, i, 1);
        scan(5);
        check("ovf_count", 32'(o_active_count), 8);
        check("ovf_flag", 32'(o_overflow), 1);
        query_direct(460, 0, 0, 0, 0, 0);
        query_direct(355, 1, 21, 7, 5, 5);
        drain();
        start_scan(5);
        wait_done(5);

        // Mid-scan restart with a new line
        clear_mem();
        mem[1]  = mk(10, 100, 30, 10, 3, 1);
        mem[20] = mk(40, 300, 30, 10, 9, 1);
        start_scan(105);
        repeat (12) @(negedge clk);
        check("idx_cycle12", 32'(o_spirit_idx), 12);
        start_scan(305);
        wait_done(305);
        check("restart_count", 32'(o_active_count), 1);
        query_direct(20, 0, 0, 0, 0, 0);
        query_direct(45, 1, 20, 9, 5, 5);
        drain();

        // Bottom-edge sprite
        clear_mem();
        mem[0] = mk(10, 1020, 3, 15, 4, 1);
        scan(1023);
        query_direct(12, 1, 0, 4, 2, 3);
        drain();
        scan(1019);
        check("above_count", 32'(o_active_count), 0);
        query_direct(12, 0, 0, 0, 0, 0);
        drain();

        // Reset during a scan
        start_scan(1023);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_done = 0;
        check("rst_mid_busy", 32'(o_scan_busy), 0);
        check("rst_mid_done", 32'(o_scan_done), 0);
        check("rst_mid_idx", 32'(o_spirit_idx), 0);
        query_direct(12, 0, 0, 0, 0, 0);
        query_direct(11, 0, 0, 0, 0, 0);
        drain();

        // Randomized lines against the reference model
        for (int t = 0; t < 20; t++) begin
            int ly;
            ly = int'($urandom_range(0, 1023));
            for (int i = 0; i < 32; i++) begin
                int y;
                y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                                : ly - int'($urandom_range(0, 40));
                if (y < 0) y = 0;
                mem[i] = {$urandom, $urandom};
                mem[i][25:16] = 10'(y);
                mem[i][47:40] = 8'($urandom_range(0, 60));
                mem[i][63]    = ($urandom_range(0, 3) != 0);
            end
            scan(ly);
            for (int q = 0; q < 30; q++) begin
                int px;
                if (m_idx.size() > 0 && $urandom_range(0, 2) != 0) begin
                    int k;
                    k  = int'($urandom_range(0, m_idx.size() - 1));
                    px = m_x[k] + int'($urandom_range(0, m_w[k] + 2));
                    if (px > 1023) px = 1023;
                end else begin
                    px = int'($urandom_range(0, 1023));
                end
                query_model(px);
            end
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spirit_line_scanner.md
Name: spirit_line_scanner

Overview:
- Sits directly downstream of the sprite ("spirit") memory in the video pipeline.
- At the start of each scanline, walks all 32 sprite entries through the memory read port (index out, 64-bit position struct back). It latches the sprites that intersect the current line into a small active list.
- During the visible portion of the line, answers per-pixel hit queries with 1-cycle latency: the winning sprite, its texture id, and texel coordinates for the texture fetch stage.

Parameters:
- MAX_ACTIVE, 8, maximum sprites latched per line; further hits are dropped.
- RD_LATENCY, 1, cycles from o_spirit_idx to valid i_spirit_position_struct. Fixed at 1 for the current memory.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_line_start  in  1  one-cycle pulse; begins a scan for line i_line_y
- i_line_y  in  10  current line number, sampled on i_line_start
- o_spirit_idx  out  5  sprite memory read index
- i_spirit_position_struct  in  64  struct returned by sprite memory
- i_pixel_x  in  10  pixel column being queried, every cycle
- o_hit  out  1  queried pixel covered by a sprite
- o_hit_idx  out  5  sprite index of the winner
- o_tex_id  out  5  texture id of the winner
- o_tex_u  out  8  column within sprite (i_pixel_x - x_pos)
- o_tex_v  out  8  row within sprite (line_y - y_pos)
- o_scan_busy  out  1  scan in progress
- o_scan_done  out  1  active list valid for current line
- o_active_count  out  4  entries latched, 0..MAX_ACTIVE
- o_overflow  out  1  more than MAX_ACTIVE sprites hit this line

Behaviour:
- Struct layout:
  - [9:0] x_pos; [25:16] y_pos
  - [39:32] width_m1; [47:40] height_m1
  - [52:48] tex_id; [63] enable
  - all other bits ignored
- Reset: state IDLE; all outputs 0; active list cleared; latched line_y = 0.
- FSM states:
  - IDLE: o_spirit_idx=0. On i_line_start, go to SCAN.
  - SCAN: issue indices in order.
  - DONE: hold the list.
- On i_line_start (any state, including mid-SCAN):
  - latch i_line_y; active count := 0; o_overflow := 0; o_scan_done := 0
  - read counter := 0; state := SCAN (mid-SCAN pulse restarts cleanly)
- SCAN timing:
  - Cycle k (k=0..31): o_spirit_idx=k.
  - Struct for index k is evaluated in cycle k+1.
  - Evaluation ends at cycle 32; state DONE at cycle 33, with o_scan_done=1 and o_scan_busy=0.
  - o_scan_busy=1 throughout SCAN.
- Hit test, 11-bit unsigned arithmetic, no wrap:
  - enable=1
  - y_pos <= line_y <= y_pos + height_m1
  - sprites extending past line 1023 still match correctly
- On hit with count < MAX_ACTIVE:
  - store {idx, x_pos, width_m1, tex_id, v = line_y - y_pos (8 bits)}
  - count++
- On hit with count == MAX_ACTIVE: entry dropped; o_overflow := 1, sticky until next i_line_start.
- List order equals ascending sprite index, so lower index has priority.
- Pixel query:
  - Registered, 1-cycle latency: outputs in cycle n+1 reflect i_pixel_x of cycle n.
  - Winner = lowest-position valid entry with x_pos <= px <= x_pos + width_m1 (11-bit compare).
  - o_tex_u = px - x_pos (low 8 bits).
  - No winner, or state != DONE: o_hit=0, and o_hit_idx/o_tex_id/o_tex_u/o_tex_v = 0.
- rst mid-scan: immediate return to IDLE; list invalid; queries miss until the next full scan.
- i_line_start coinciding with rst: rst wins.

Test Plan:
- Reset, then query px=100 -> o_hit=0, all outputs 0, o_scan_done=0, o_spirit_idx=0.
- Sprite 3 = {x=100, y=50, w_m1=15, h_m1=15, tex=7, en=1}, others disabled; line_start y=60; wait 33 cycles; query px=105 ->
  - next cycle o_hit=1, idx=3, tex_id=7, u=5, v=10
  - px=116 -> o_hit=0
  - o_active_count=1
- Sprites 2 and 9 overlap at x=200 on line 10, both enabled -> query px=200 gives o_hit_idx=2. With sprite 2 disabled -> o_hit_idx=9.
- Ten enabled sprites all covering line 5 -> o_active_count=8, o_overflow=1; the next line_start clears o_overflow to 0 in the following cycle.
- Mid-scan i_line_start (at cycle 12) with a new y -> o_spirit_idx restarts at 0; o_scan_done asserts 33 cycles after the second pulse; the list reflects only the new y.
- Boundary: sprite y=1020, h_m1=15, line_y=1023 -> hit with v=3. Line_y=1019 -> no hit. rst during SCAN -> o_scan_busy=0 next cycle, queries miss.
